serial_job_scheduler: RTL and testbench
=======================================

SERIAL_JOB_SCHEDULER -- requirements
Module: serial_job_scheduler

Interface
REQ-001 SHALL have parameter MAX_JOBS, default 4, maximum accepted job count per start (range 1..7).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum RUN cycles per job before abort-on-timeout.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  launch request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  cancel current sequence.
REQ-007 SHALL have port job_cnt  input  3  jobs to run; latched at start.
REQ-008 SHALL have port feature_base  input  8  feature base address of job 0; latched at start.
REQ-009 SHALL have port feature_stride  input  8  base-address increment per job; latched at start.
REQ-010 SHALL have port result_base  input  6  memory address of job 0 result; latched at start.
REQ-011 SHALL have port eng_en  output  1  enable to serial engine.
REQ-012 SHALL have port eng_feature_baseaddr  output  8  feature base address for the current job.
REQ-013 SHALL have ports eng_addr/eng_we/eng_done/eng_out  input  6/1/1/8  engine memory address, write enable, done flag, result.
REQ-014 SHALL have ports mem_addr/mem_we/mem_d  output  6/1/8  shared single-port memory interface.
REQ-015 SHALL have ports busy/done/timeout_err  output  1/1/1  status; done and timeout_err are 1-cycle pulses.
REQ-016 SHALL have ports jobs_done/last_result  output  3/8  completed job count, most recent engine result.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, RUN, WB, FIN.
REQ-018 IDLE: start=1 and 1<=job_cnt<=MAX_JOBS -> latch inputs, idx=0, jobs_done=0, go LAUNCH; start with job_cnt=0 or >MAX_JOBS -> done pulse next cycle, stay IDLE, no job runs.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 LAUNCH (1 cycle): eng_en=0, eng_feature_baseaddr=(feature_base+idx*feature_stride) mod 256, watchdog cleared; next RUN.
REQ-021 RUN: eng_en=1, mem_addr=eng_addr, mem_we=eng_we, mem_d=0; watchdog increments each cycle.
REQ-022 RUN with eng_done=1: last_result<=eng_out, go WB next cycle.
REQ-023 RUN with watchdog reaching TIMEOUT and eng_done=0: timeout_err pulse, eng_en=0 next cycle, go IDLE, no done pulse, jobs_done unchanged.
REQ-024 WB (1 cycle): eng_en=0, mem_addr=(result_base+idx) mod 64, mem_we=1, mem_d=last_result; jobs_done increments; idx increments; next LAUNCH if new idx<job_cnt else FIN.
REQ-025 FIN (1 cycle): done=1; next IDLE.
REQ-026 Outside RUN and WB, mem_addr=0, mem_we=0, mem_d=0; engine eng_we SHALL never reach mem_we outside RUN.
REQ-027 busy SHALL be 1 in LAUNCH, RUN, WB, FIN and 0 in IDLE.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, eng_en=0, mem_we=0, no done pulse; abort has priority over eng_done and timeout in the same cycle.
REQ-029 eng_done and watchdog expiry in the same RUN cycle: eng_done wins.
REQ-030 last_result and jobs_done SHALL hold after FIN/abort until next accepted start.

Reset
REQ-031 rst=0 SHALL immediately force IDLE and all outputs and registers to 0, including mid-RUN (eng_en drops asynchronously).
REQ-032 First FSM action after rst release SHALL occur on the first rising edge with rst=1.

Verification
REQ-033 start, job_cnt=1, feature_base=0x10, result_base=0x20, eng_done after 5 RUN cycles with eng_out=0x3C -> eng_feature_baseaddr=0x10, WB write 0x3C to addr 0x20, done pulse, jobs_done=1.
REQ-034 job_cnt=3, feature_base=0xF0, stride=0x08, result_base=0x3F -> base addresses 0xF0,0xF8,0x00; results written to 0x3F,0x00,0x01; eng_en low one cycle between jobs.
REQ-035 job_cnt=0 start -> done pulse next cycle, busy never asserted, mem_we never asserted.
REQ-036 TIMEOUT=8, eng_done held low -> timeout_err pulse after 8 RUN cycles, return IDLE, no WB write, no done.
REQ-037 abort asserted same cycle as eng_done in job 1 of 2 -> IDLE next cycle, no WB write, jobs_done=0, no done.
REQ-038 rst low mid-RUN, eng_we=1 -> mem_we, eng_en, busy 0 immediately; second start during busy ignored.

Source files
------------

// File: rtl/serial_job_scheduler_if.sv
// Engine and shared-memory bus between the job scheduler (master) and the
// serial engine / memory side (slave).
interface serial_job_scheduler_if;
    logic       eng_en;
    logic [7:0] eng_feature_baseaddr;
    logic [5:0] eng_addr;
    logic       eng_we;
    logic       eng_done;
    logic [7:0] eng_out;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_d;

    modport master (
        output eng_en, eng_feature_baseaddr, mem_addr, mem_we, mem_d,
        input  eng_addr, eng_we, eng_done, eng_out
    );

    modport slave (
        input  eng_en, eng_feature_baseaddr, mem_addr, mem_we, mem_d,
        output eng_addr, eng_we, eng_done, eng_out
    );
endinterface

// File: rtl/serial_job_scheduler.sv
// Runs a batch of jobs back-to-back on a serial engine, writing each result to
// consecutive memory addresses, with a per-job watchdog and abort.
module serial_job_scheduler #(
    parameter int MAX_JOBS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [2:0]                job_cnt,
    input  logic [7:0]                feature_base,
    input  logic [7:0]                feature_stride,
    input  logic [5:0]                result_base,
    serial_job_scheduler_if.master    bus,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [2:0]                jobs_done,
    output logic [7:0]                last_result
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    localparam int              WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]      MAX_C   = 3'(MAX_JOBS);

    logic [2:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      base_q, base_d;
    logic [7:0]      stride_q, stride_d;
    logic [5:0]      rbase_q, rbase_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [2:0]      jobs_done_q, jobs_done_d;
    logic [7:0]      last_result_q, last_result_d;
    logic            rej_q, rej_d;
    logic            to_q, to_d;
    logic [2:0]      idx_nx;

    assign idx_nx = idx_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        base_d        = base_q;
        stride_d      = stride_q;
        rbase_d       = rbase_q;
        wd_d          = wd_q;
        jobs_done_d   = jobs_done_q;
        last_result_d = last_result_q;
        rej_d         = 1'b0;
        to_d          = 1'b0;
        // Abort outranks engine completion and watchdog expiry.
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (job_cnt != 3'd0 && job_cnt <= MAX_C) begin
                            cnt_d       = job_cnt;
                            base_d      = feature_base;
                            stride_d    = feature_stride;
                            rbase_d     = result_base;
                            idx_d       = 3'd0;
                            jobs_done_d = 3'd0;
                            state_d     = S_LAUNCH;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    wd_d    = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.eng_done) begin
                        last_result_d = bus.eng_out;
                        state_d       = S_WB;
                    end else if (wd_q == WD_LAST) begin
                        to_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                S_WB: begin
                    jobs_done_d = jobs_done_q + 3'd1;
                    idx_d       = idx_nx;
                    // Stepping the base here keeps LAUNCH free of a multiplier.
                    base_d      = base_q + stride_q;
                    state_d     = (idx_nx < cnt_q) ? S_LAUNCH : S_FIN;
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            base_q        <= '0;
            stride_q      <= '0;
            rbase_q       <= '0;
            wd_q          <= '0;
            jobs_done_q   <= '0;
            last_result_q <= '0;
            rej_q         <= 1'b0;
            to_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            rbase_q       <= rbase_d;
            wd_q          <= wd_d;
            jobs_done_q   <= jobs_done_d;
            last_result_q <= last_result_d;
            rej_q         <= rej_d;
            to_q          <= to_d;
        end
    end

    // Memory mux: engine owns the port only in RUN, scheduler only in WB.
    always_comb begin
        bus.mem_addr = 6'd0;
        bus.mem_we   = 1'b0;
        bus.mem_d    = 8'd0;
        if (state_q == S_RUN) begin
            bus.mem_addr = bus.eng_addr;
            bus.mem_we   = bus.eng_we;
        end else if (state_q == S_WB) begin
            bus.mem_addr = rbase_q + {3'd0, idx_q};
            bus.mem_we   = ~abort;
            bus.mem_d    = last_result_q;
        end
    end

    assign bus.eng_en               = (state_q == S_RUN);
    assign bus.eng_feature_baseaddr = base_q;
    assign busy                     = (state_q != S_IDLE);
    assign done                     = rej_q | ((state_q == S_FIN) & ~abort);
    assign timeout_err              = to_q;
    assign jobs_done                = jobs_done_q;
    assign last_result              = last_result_q;
endmodule

// File: tb/tb_serial_job_scheduler.sv
// Bench for serial_job_scheduler: acts as the serial engine and compares the
// scheduler against a job-level model of the expected batch behaviour.
module tb_serial_job_scheduler;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] job_cnt = 3'd0;
    logic [7:0] feature_base = 8'd0;
    logic [7:0] feature_stride = 8'd0;
    logic [5:0] result_base = 6'd0;
    logic       busy, done, timeout_err;
    logic [2:0] jobs_done;
    logic [7:0] last_result;

    int         total = 0;
    int         bad = 0;
    int         lat_a [8];
    logic [7:0] out_a [8];
    int         m_jobs_done = 0;
    logic [7:0] m_last = 8'd0;

    serial_job_scheduler_if bus();

    serial_job_scheduler #(.MAX_JOBS(4), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .job_cnt        (job_cnt),
        .feature_base   (feature_base),
        .feature_stride (feature_stride),
        .result_base    (result_base),
        .bus            (bus.master),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .jobs_done      (jobs_done),
        .last_result    (last_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One batch; lat_a[j]==0 means job j never finishes, abort_job aborts that
    // job in the same cycle as its eng_done.
    task automatic run_seq(input int cnt, input logic [7:0] fb, input logic [7:0] st,
                           input logic [5:0] rb, input int abort_job);
        logic fin_now;
        tick();
        start = 1'b1; job_cnt = 3'(cnt); feature_base = fb; feature_stride = st; result_base = rb;
        tick();
        start = 1'b0; job_cnt = 3'($urandom); feature_base = 8'($urandom);
        feature_stride = 8'($urandom); result_base = 6'($urandom);
        m_jobs_done = 0;
        for (int j = 0; j < cnt; j++) begin
            #1;
            chk("launch_busy", 32'(busy), 32'd1);
            chk("launch_en", 32'(bus.eng_en), 32'd0);
            chk("launch_base", 32'(bus.eng_feature_baseaddr), 32'((int'(fb) + j * int'(st)) % 256));
            chk("launch_we", 32'(bus.mem_we), 32'd0);
            tick();
            for (int k = 1; k <= TMO; k++) begin
                fin_now = (lat_a[j] == k);
                bus.eng_addr = 6'($urandom); bus.eng_we = 1'($urandom);
                bus.eng_out = 8'($urandom); bus.eng_done = fin_now;
                start = 1'($urandom); job_cnt = 3'd1;
                if (fin_now) bus.eng_out = out_a[j];
                if (fin_now && j == abort_job) begin abort = 1'b1; bus.eng_we = 1'b0; end
                #1;
                chk("run_en", 32'(bus.eng_en), 32'd1);
                chk("run_maddr", 32'(bus.mem_addr), 32'(bus.eng_addr));
                chk("run_mwe", 32'(bus.mem_we), 32'(bus.eng_we));
                chk("run_md", 32'(bus.mem_d), 32'd0);
                tick();
                if (fin_now) break;
            end
            start = 1'b0; abort = 1'b0; bus.eng_done = 1'b0; bus.eng_we = 1'b0;
            if (lat_a[j] == 0) begin
                #1;
                chk("to_pulse", 32'(timeout_err), 32'd1);
                chk("to_en", 32'(bus.eng_en), 32'd0);
                chk("to_busy", 32'(busy), 32'd0);
                chk("to_done", 32'(done), 32'd0);
                chk("to_jobs", 32'(jobs_done), 32'(m_jobs_done));
                tick(); #1;
                chk("to_pulse_end", 32'(timeout_err), 32'd0);
                chk("to_no_done", 32'(done), 32'd0);
                return;
            end
            if (j == abort_job) begin
                #1;
                chk("ab_busy", 32'(busy), 32'd0);
                chk("ab_en", 32'(bus.eng_en), 32'd0);
                chk("ab_we", 32'(bus.mem_we), 32'd0);
                chk("ab_done", 32'(done), 32'd0);
                chk("ab_jobs", 32'(jobs_done), 32'(m_jobs_done));
                return;
            end
            #1;
            chk("wb_we", 32'(bus.mem_we), 32'd1);
            chk("wb_addr", 32'(bus.mem_addr), 32'((int'(rb) + j) % 64));
            chk("wb_data", 32'(bus.mem_d), 32'(out_a[j]));
            chk("wb_en", 32'(bus.eng_en), 32'd0);
            m_jobs_done++;
            m_last = out_a[j];
            tick();
        end
        #1;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd1);
        chk("fin_we", 32'(bus.mem_we), 32'd0);
        start = 1'b1; job_cnt = 3'd1;
        tick();
        start = 1'b0;
        #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_jobs", 32'(jobs_done), 32'(m_jobs_done));
        chk("idle_last", 32'(last_result), 32'(m_last));
    endtask

    task automatic rej(input logic [2:0] c);
        tick();
        start = 1'b1; job_cnt = c;
        #1;
        chk("rej_busy0", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        #1;
        chk("rej_done", 32'(done), 32'd1);
        chk("rej_busy1", 32'(busy), 32'd0);
        chk("rej_we", 32'(bus.mem_we), 32'd0);
        chk("rej_maddr", 32'(bus.mem_addr), 32'd0);
        chk("rej_jobs", 32'(jobs_done), 32'(m_jobs_done));
        tick(); #1;
        chk("rej_done_end", 32'(done), 32'd0);
        chk("rej_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        int c, ab;
        bus.eng_addr = 6'd0; bus.eng_we = 1'b0; bus.eng_done = 1'b0; bus.eng_out = 8'd0;
        repeat (3) tick();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        chk("rst_en", 32'(bus.eng_en), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_base", 32'(bus.eng_feature_baseaddr), 32'd0);
        chk("rst_jobs", 32'(jobs_done), 32'd0);
        chk("rst_last", 32'(last_result), 32'd0);
        tick();
        rst = 1'b1;

        lat_a[0] = 5; out_a[0] = 8'h3C;
        run_seq(1, 8'h10, 8'h04, 6'h20, -1);

        for (int j = 0; j < 8; j++) begin lat_a[j] = $urandom_range(1, TMO); out_a[j] = 8'($urandom); end
        lat_a[1] = TMO;
        run_seq(3, 8'hF0, 8'h08, 6'h3F, -1);

        rej(3'd0);
        rej(3'd5);
        rej(3'd7);

        lat_a[0] = 0;
        run_seq(1, 8'h22, 8'h01, 6'h05, -1);
        lat_a[0] = 2; lat_a[1] = 0;
        run_seq(3, 8'h80, 8'h40, 6'h10, -1);

        lat_a[0] = 3; lat_a[1] = 4;
        run_seq(2, 8'h01, 8'h02, 6'h03, 0);

        // Asynchronous reset in the middle of RUN, then start on the release edge.
        tick();
        start = 1'b1; job_cnt = 3'd2; feature_base = 8'h55;
        tick(); start = 1'b0;
        tick();
        bus.eng_we = 1'b1; bus.eng_addr = 6'h15;
        #1;
        chk("mr_we_hi", 32'(bus.mem_we), 32'd1);
        chk("mr_en_hi", 32'(bus.eng_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mr_we", 32'(bus.mem_we), 32'd0);
        chk("mr_en", 32'(bus.eng_en), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_jobs", 32'(jobs_done), 32'd0);
        chk("mr_last", 32'(last_result), 32'd0);
        tick();
        rst = 1'b1; start = 1'b1; job_cnt = 3'd1; bus.eng_we = 1'b0;
        tick(); start = 1'b0;
        #1;
        chk("rel_launch_busy", 32'(busy), 32'd1);
        chk("rel_launch_en", 32'(bus.eng_en), 32'd0);
        tick(); #1;
        chk("rel_run_en", 32'(bus.eng_en), 32'd1);
        abort = 1'b1;
        tick(); abort = 1'b0;
        #1;
        chk("rel_abort_busy", 32'(busy), 32'd0);
        m_jobs_done = 0;

        for (int it = 0; it < 25; it++) begin
            c = $urandom_range(1, 4);
            ab = -1;
            for (int j = 0; j < 8; j++) begin lat_a[j] = $urandom_range(1, TMO); out_a[j] = 8'($urandom); end
            if ($urandom_range(0, 4) == 0) lat_a[$urandom_range(0, c - 1)] = 0;
            if ($urandom_range(0, 4) == 0) ab = $urandom_range(0, c - 1);
            run_seq(c, 8'($urandom), 8'($urandom), 6'($urandom), ab);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
